// File: rtl/ramreader_n_pkg.sv
// Shared definitions for the multi-byte RAM reader and the sequencer that drives it.
package ramreader_n_pkg;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    localparam int MAXLEN = 8;

    // Transfer lengths the sequencer selects from the opcode class.
    localparam logic [3:0] LEN_OP_WORD = 4'd8;
    localparam logic [3:0] LEN_OP_HALF = 4'd4;
    localparam logic [3:0] LEN_OP_BYTE = 4'd1;

endpackage

// File: rtl/ramreader_n_ext.sv
// Result extension: bytes at or above len are zero or copies of the top captured bit.
module ramreader_ext
    import ramreader_n_pkg::*;
#(
    parameter int NB = MAXLEN
) (
    input  logic [8*NB-1:0]          i_word,
    input  logic [$clog2(NB+1)-1:0]  i_len,
    input  logic                     i_sext,
    output logic [8*NB-1:0]          o_ext
);

    localparam int LW = $clog2(NB+1);

    logic [LW-1:0] w_top;
    logic          w_sign;
    logic          w_fill;

    // Pick the sign bit of the highest valid byte, then fill the unused lanes.
    always_comb begin
        w_top  = i_len - LW'(1);
        w_sign = 1'b0;
        o_ext  = '0;
        for (int i = 0; i < NB; i++) begin
            w_sign = (LW'(i) == w_top) ? i_word[8*i+7] : w_sign;
        end
        w_fill = i_sext & w_sign;
        for (int i = 0; i < NB; i++) begin
            o_ext[8*i +: 8] = (LW'(i) < i_len) ? i_word[8*i +: 8] : {8{w_fill}};
        end
    end

endmodule

// File: rtl/ramreader_n.sv
// Multi-byte reader: streams len consecutive RAM addresses and packs the bytes into q.
module ramreader_n
    import ramreader_n_pkg::*;
#(
    parameter int AW = 16,
    parameter int NB = MAXLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [AW-1:0]            addr,
    input  logic [$clog2(NB+1)-1:0]  len,
    input  logic                     bigend,
    input  logic                     sext,
    input  logic                     abort,
    input  logic [7:0]               d,
    output logic                     kp,
    output logic                     re,
    output logic [AW-1:0]            adq,
    output logic [8*NB-1:0]          q,
    output logic                     done,
    output logic                     err
);

    localparam int            LW   = $clog2(NB+1);
    localparam logic [LW-1:0] NB_L = LW'(NB);

    rd_state_t       r_state;
    logic [LW-1:0]   r_len;
    logic            r_bigend;
    logic            r_sext;
    logic [LW-1:0]   r_issue;
    logic [LW-1:0]   r_cap;
    logic [AW-1:0]   r_adq;
    logic            r_re;
    logic            r_kp;
    logic [8*NB-1:0] r_q;
    logic            r_done;
    logic            r_err;

    logic [LW-1:0]   w_slot;
    logic [8*NB-1:0] w_asm;
    logic [8*NB-1:0] w_ext;
    logic            w_last;
    logic            w_len_ok;

    assign w_len_ok = (len != '0) && (len <= NB_L);
    assign w_last   = (r_cap == r_len - LW'(1));

    // Steer the incoming byte into its lane; big-endian fills from the top lane down.
    always_comb begin
        if (r_bigend) begin
            w_slot = r_len - r_cap - LW'(1);
        end else begin
            w_slot = r_cap;
        end
        w_asm = r_q;
        for (int i = 0; i < NB; i++) begin
            if (LW'(i) == w_slot) begin
                w_asm[8*i +: 8] = d;
            end else begin
                w_asm[8*i +: 8] = r_q[8*i +: 8];
            end
        end
    end

    ramreader_ext #(
        .NB (NB)
    ) u_ext (
        .i_word (w_asm),
        .i_len  (r_len),
        .i_sext (r_sext),
        .o_ext  (w_ext)
    );

    // Transfer sequencing; abort takes priority over the completing capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RD_IDLE;
            r_len    <= '0;
            r_bigend <= 1'b0;
            r_sext   <= 1'b0;
            r_issue  <= '0;
            r_cap    <= '0;
            r_adq    <= '0;
            r_re     <= 1'b0;
            r_kp     <= 1'b0;
            r_q      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                RD_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_adq    <= addr;
                            r_re     <= 1'b1;
                            r_kp     <= 1'b1;
                            r_q      <= '0;
                            r_len    <= len;
                            r_bigend <= bigend;
                            r_sext   <= sext;
                            r_issue  <= LW'(1);
                            r_cap    <= '0;
                            r_state  <= RD_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RD_RUN: begin
                    if (abort) begin
                        r_kp    <= 1'b0;
                        r_re    <= 1'b0;
                        r_state <= RD_IDLE;
                    end else if (w_last) begin
                        r_q     <= w_ext;
                        r_cap   <= r_cap + LW'(1);
                        r_done  <= 1'b1;
                        r_kp    <= 1'b0;
                        r_re    <= 1'b0;
                        r_state <= RD_IDLE;
                    end else begin
                        r_q   <= w_asm;
                        r_cap <= r_cap + LW'(1);
                        if (r_issue < r_len) begin
                            r_adq   <= r_adq + AW'(1);
                            r_re    <= 1'b1;
                            r_issue <= r_issue + LW'(1);
                        end else begin
                            r_re <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_kp    <= 1'b0;
                    r_re    <= 1'b0;
                    r_state <= RD_IDLE;
                end
            endcase
        end
    end

    assign kp   = r_kp;
    assign re   = r_re;
    assign adq  = r_adq;
    assign q    = r_q;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_ramreader_n.sv
// Directed bench for ramreader_n: table of transfers plus abort, overlap and reset sequences.
module tb_ramreader_n;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] addr;
    logic [3:0]  len;
    logic        bigend;
    logic        sext;
    logic        abort;
    logic [7:0]  d;
    logic        kp;
    logic        re;
    logic [15:0] adq;
    logic [63:0] q;
    logic        done;
    logic        err;

    logic [7:0]  mem [0:65535];

    int n_vec;
    int n_bad;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  len;
        logic        be;
        logic        sx;
        logic        is_err;
        logic [63:0] q;
    } vec_t;

    vec_t tbl [11];

    ramreader_n dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .addr   (addr),
        .len    (len),
        .bigend (bigend),
        .sext   (sext),
        .abort  (abort),
        .d      (d),
        .kp     (kp),
        .re     (re),
        .adq    (adq),
        .q      (q),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read RAM model: data for adq is presented during the following cycle.
    assign d = re ? mem[adq] : 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] a;
        @(negedge clk);
        addr = v.addr; len = v.len; bigend = v.be; sext = v.sx; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (v.is_err) begin
            @(negedge clk);
            chk("err_pulse", 64'(err), 64'd1);
            chk("err_kp", 64'(kp), 64'd0);
            chk("err_re", 64'(re), 64'd0);
            chk("err_q_held", q, v.q);
            @(negedge clk);
            chk("err_one_cycle", 64'(err), 64'd0);
        end else begin
            for (int k = 0; k < int'(v.len); k++) begin
                @(negedge clk);
                a = v.addr + 16'(k);
                chk("run_re", 64'(re), 64'd1);
                chk("run_kp", 64'(kp), 64'd1);
                chk("run_adq", 64'(adq), 64'(a));
                chk("run_no_done", 64'(done), 64'd0);
                chk("run_no_err", 64'(err), 64'd0);
            end
            @(negedge clk);
            chk("done_pulse", 64'(done), 64'd1);
            chk("done_kp", 64'(kp), 64'd0);
            chk("done_re", 64'(re), 64'd0);
            chk("done_q", q, v.q);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("q_hold", q, v.q);
        end
    endtask

    initial begin
        int seen;
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'(i + 1);
        mem[16'h0200] = 8'hF1; mem[16'h0201] = 8'h22;
        mem[16'h0202] = 8'h33; mem[16'h0203] = 8'h44;
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h80; mem[16'h0000] = 8'h22;
        mem[16'h0300] = 8'h01; mem[16'h0301] = 8'h02; mem[16'h0302] = 8'h93;

        tbl[0]  = '{16'h0100, 4'd8, 1'b0, 1'b0, 1'b0, 64'h0807060504030201};
        tbl[1]  = '{16'h0100, 4'd8, 1'b1, 1'b0, 1'b0, 64'h0102030405060708};
        tbl[2]  = '{16'h0200, 4'd4, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFF1223344};
        tbl[3]  = '{16'h0200, 4'd4, 1'b1, 1'b0, 1'b0, 64'h00000000F1223344};
        tbl[4]  = '{16'hFFFF, 4'd1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFF80};
        tbl[5]  = '{16'h1234, 4'd0, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFF80};
        tbl[6]  = '{16'h1234, 4'd9, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFF80};
        tbl[7]  = '{16'hFFFE, 4'd3, 1'b0, 1'b0, 1'b0, 64'h0000000000228011};
        tbl[8]  = '{16'h0300, 4'd3, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFF930201};
        tbl[9]  = '{16'h0200, 4'd2, 1'b0, 1'b1, 1'b0, 64'h00000000000022F1};
        tbl[10] = '{16'h0300, 4'd3, 1'b1, 1'b0, 1'b0, 64'h0000000000010293};

        rst_n = 1'b0; start = 1'b0; addr = 16'h0000; len = 4'd0;
        bigend = 1'b0; sext = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_kp", 64'(kp), 64'd0);
        chk("rst_re", 64'(re), 64'd0);
        chk("rst_adq", 64'(adq), 64'd0);
        chk("rst_q", q, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // Abort one cycle after the third capture: bytes 0..2 kept, no extension, no done.
        @(negedge clk);
        addr = 16'h0100; len = 4'd8; bigend = 1'b0; sext = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_kp", 64'(kp), 64'd0);
        chk("abort_re", 64'(re), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_q", q, 64'h0000000000030201);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_late_done", 64'(seen), 64'd0);
        chk("abort_q_hold", q, 64'h0000000000030201);
        run_vec(tbl[3]);

        // Start (with an illegal len) re-asserted mid-transfer must be ignored.
        @(negedge clk);
        addr = 16'h0200; len = 4'd4; bigend = 1'b1; sext = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b1; addr = 16'h0100; len = 4'd0;
            end else begin
                start = 1'b0;
            end
            if (err) seen++;
        end
        start = 1'b0;
        @(negedge clk);
        if (err) seen++;
        chk("ovl_done", 64'(done), 64'd1);
        chk("ovl_q", q, 64'h00000000F1223344);
        chk("ovl_no_err", 64'(seen), 64'd0);

        // Reset mid-transfer clears outputs asynchronously and suppresses done.
        @(negedge clk);
        addr = 16'h0100; len = 4'd8; bigend = 1'b0; sext = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", q, 64'd0);
        chk("arst_adq", 64'(adq), 64'd0);
        chk("arst_kp", 64'(kp), 64'd0);
        chk("arst_re", 64'(re), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || kp) seen++;
        end
        chk("arst_quiet", 64'(seen), 64'd0);
        run_vec(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
